// File: rtl/marquee_pkg.sv
// marquee_pkg: shared types and widths for the rotate_marquee LED chaser.
//   marquee_state_t : FSM encoding (IDLE after reset, RUN while chasing)
//   PAT_W           : pattern width (8 LEDs)
//   AMT_W           : rotate-distance width (0..7)
package marquee_pkg;

    typedef enum logic {IDLE, RUN} marquee_state_t;

    localparam int PAT_W = 8;
    localparam int AMT_W = 3;

endpackage

// File: rtl/barrelshifter.sv
// barrelshifter: combinational 8-bit rotator.
//   lr  : 1 = rotate left, 0 = rotate right
//   a   : value to rotate
//   amt : rotate distance, 0..7
//   y   : rotated value
module barrelshifter
    import marquee_pkg::*;
(
    input  logic             lr,
    input  logic [PAT_W-1:0] a,
    input  logic [AMT_W-1:0] amt,
    output logic [PAT_W-1:0] y
);

    // The AMT_W-bit index arithmetic wraps modulo PAT_W, which is exactly
    // the rotate wrap-around.
    always_comb begin
        y = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (lr) y[i] = a[AMT_W'(i) - amt];
            else    y[i] = a[AMT_W'(i) + amt];
        end
    end

endmodule

// File: rtl/rotate_marquee.sv
// rotate_marquee: sequential front-end for barrelshifter producing an LED
// chaser. A pattern register is rotated by amt positions every div+1 clocks
// while running.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : strobe, q <= pattern and prescaler cleared (either state)
//   pattern     : value to load
//   start, stop : strobes, IDLE->RUN / RUN->IDLE (stop wins over start)
//   dir         : 1 = rotate left, 0 = rotate right (sampled on a step)
//   amt         : rotate distance per step
//   div         : step period minus one, in clocks
//   q           : pattern register
//   step_pulse  : one-cycle flag in the cycle q shows a stepped value
//   running     : high in RUN
// Optional macro MARQUEE_BOUNCE_EN: ping-pong direction, flipping after
// every 7 steps; dir is only captured on start and load.
module rotate_marquee
    import marquee_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [AMT_W-1:0] amt,
    input  logic [DIV_W-1:0] div,
    output logic [PAT_W-1:0] q,
    output logic             step_pulse,
    output logic             running
);

    marquee_state_t   state, next_state;
    logic [DIV_W-1:0] cnt;
    logic [PAT_W-1:0] rot_y;
    logic             dir_eff;
    logic             step_fire;

    // Priority inside RUN: stop suppresses everything, then load, then start
    // (which only clears the prescaler); only an undisturbed cycle may step.
    assign step_fire = (state == RUN) && !stop && !load && !start && (cnt == div);
    assign running   = (state == RUN);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && !stop) next_state = RUN;
            RUN:     if (stop)           next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- Prescaler ----------------
    // Lowering div below cnt makes cnt run on and wrap through 2^DIV_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == RUN && stop) begin
            cnt <= cnt;
        end else if (load || start) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= (cnt == div) ? '0 : cnt + DIV_W'(1);
        end
    end

    // ---------------- Pattern register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= step_fire;
            if (load)           q <= pattern;
            else if (step_fire) q <= rot_y;
        end
    end

    // ---------------- Direction ----------------
`ifdef MARQUEE_BOUNCE_EN
    logic       dir_r;
    logic [2:0] bcnt;

    // Flip on the 7th step so the 8th step already runs the other way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_r <= 1'b0;
            bcnt  <= '0;
        end else if (load || (state == IDLE && start && !stop)) begin
            dir_r <= dir;
            bcnt  <= '0;
        end else if (step_fire) begin
            if (bcnt == 3'd6) begin
                bcnt  <= '0;
                dir_r <= ~dir_r;
            end else begin
                bcnt  <= bcnt + 3'd1;
            end
        end
    end

    assign dir_eff = dir_r;
`else
    assign dir_eff = dir;
`endif

    barrelshifter u_rot (
        .lr  (dir_eff),
        .a   (q),
        .amt (amt),
        .y   (rot_y)
    );

endmodule

// File: tb/tb_rotate_marquee.sv
// Scoreboard bench for rotate_marquee: stimulus pushes the expected q of each
// step into a queue, the monitor pops one entry per step_pulse.
module tb_rotate_marquee;
    import marquee_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load, start, stop, dir;
    logic [7:0]  pattern;
    logic [2:0]  amt;
    logic [23:0] div;
    logic [7:0]  q;
    logic        step_pulse, running;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    rotate_marquee #(.DIV_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .pattern(pattern),
        .start(start), .stop(stop), .dir(dir), .amt(amt), .div(div),
        .q(q), .step_pulse(step_pulse), .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] p);
        load = 1'b1; pattern = p; tick(); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    // Monitor: every step must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && step_pulse) begin
            if (exp_q.size() == 0) begin
                check("unexpected_step", 32'(q), 32'hFFFF_FFFF);
            end else begin
                check("step_q", 32'(q), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0; load = 0; start = 0; stop = 0; dir = 0;
        pattern = '0; amt = '0; div = '0;
        #12;
        check("rst_q", 32'(q), 0);
        check("rst_running", 32'(running), 0);
        check("rst_step", 32'(step_pulse), 0);
        #10 rst_n = 1'b1;
        tick();

        // Reset mid-run: asserted between edges, before any step is due.
        div = 24'd3; dir = 1; amt = 1;
        do_load(8'hA5);
        check("load_q", 32'(q), 32'hA5);
        do_start();
        check("run_rise", 32'(running), 1);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_q", 32'(q), 0);
        check("midrst_running", 32'(running), 0);
        check("midrst_step", 32'(step_pulse), 0);
        #20 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("post_rst_q", 32'(q), 0);
        check("post_rst_running", 32'(running), 0);

        // Basic chase: left by 1, step every 3 cycles.
        dir = 1; amt = 1; div = 24'd2;
        do_load(8'h01);
        exp_q.push_back(8'h02); exp_q.push_back(8'h04);
        exp_q.push_back(8'h08); exp_q.push_back(8'h10);
        do_start();
        check("chase_running", 32'(running), 1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("chase_pulse_%0d", i), 32'(step_pulse), 32'((i % 3) == 0));
        end
        do_stop();
        check("chase_stop_running", 32'(running), 0);
        check("chase_final_q", 32'(q), 32'h10);

        // Right rotate wrap, every cycle; stop lands on a step cycle.
        dir = 0; amt = 3; div = 24'd0;
        do_load(8'h01);
        exp_q.push_back(8'h20); exp_q.push_back(8'h04);
        exp_q.push_back(8'h80); exp_q.push_back(8'h10);
        do_start();
        for (int i = 0; i < 4; i++) tick();
        do_stop();
        check("stop_step_q", 32'(q), 32'h10);
        check("stop_step_pulse", 32'(step_pulse), 0);
        check("stop_running", 32'(running), 0);

        // Load in a step cycle beats the step.
        dir = 1; amt = 1; div = 24'd0;
        do_load(8'h01);
        exp_q.push_back(8'h02); exp_q.push_back(8'hB4); exp_q.push_back(8'h69);
        do_start();
        tick();
        do_load(8'h5A);
        check("ld_step_q", 32'(q), 32'h5A);
        check("ld_step_pulse", 32'(step_pulse), 0);
        check("ld_step_running", 32'(running), 1);
        tick(); tick();
        do_stop();
        check("ld_final_q", 32'(q), 32'h69);

        // start+stop together in IDLE.
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        check("startstop_running", 32'(running), 0);
        tick();
        check("startstop_running2", 32'(running), 0);
        check("startstop_q", 32'(q), 32'h69);

        // amt = 0 still steps, q unchanged.
        amt = 0; div = 24'd1;
        do_load(8'h3C);
        for (int i = 0; i < 3; i++) exp_q.push_back(8'h3C);
        do_start();
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("amt0_pulse_%0d", i), 32'(step_pulse), 32'((i % 2) == 0));
        end
        do_stop();
        check("amt0_q", 32'(q), 32'h3C);

`ifdef MARQUEE_BOUNCE_EN
        // Bounce: 7 steps left, then right; dir input ignored while running.
        dir = 1; amt = 1; div = 24'd0;
        do_load(8'h01);
        exp_q.push_back(8'h02); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
        exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h40);
        exp_q.push_back(8'h80); exp_q.push_back(8'h40); exp_q.push_back(8'h20);
        exp_q.push_back(8'h10);
        do_start();
        dir = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            dir = ~dir;
        end
        do_stop();
        check("bounce_q", 32'(q), 32'h10);
`endif

        tick(); tick();
        check("sb_drain", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rotate_marquee.md
# rotate_marquee

Sequential front-end for the 8-bit combinational rotator (`barrelshifter`: `lr`=1 rotates left, `a`, `amt`, `y`).
- Holds an 8-bit pattern register and drives it into the rotator.
- On each prescaler tick while running, writes the rotated value back into the register.
- Produces a marquee/LED-chaser sequence for board demos.
- Sits between the switch/button debouncers upstream and the LED driver downstream.

## Interface
- `DIV_W`, default 24: prescaler counter width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `load` input 1: single-cycle strobe; copies `pattern` into the pattern register.
- `pattern` input 8: value to load.
- `start` input 1: single-cycle strobe; IDLE→RUN.
- `stop` input 1: single-cycle strobe; RUN→IDLE.
- `dir` input 1: 1 = rotate left, 0 = rotate right.
- `amt` input 3: rotate distance per step, 0–7.
- `div` input DIV_W: step period minus one, in clocks.
- `q` output 8: pattern register.
- `step_pulse` output 1: high for exactly one cycle in the cycle `q` updates from a step.
- `running` output 1: high in RUN.

## Operation
- **States:**
  - IDLE (reset state).
  - RUN.
- **State transitions:**
  - IDLE→RUN on `start`.
  - RUN→IDLE on `stop`.
  - `start` and `stop` asserted together: `stop` wins; the state is IDLE next cycle.
  - `start` while in RUN: ignored, except that it clears the prescaler.
- **Prescaler:**
  - `cnt` (DIV_W bits) increments each RUN cycle.
  - When `cnt == div`, a step fires and `cnt` returns to 0.
  - `div`=0 gives a step every cycle.
  - If `div` is lowered below the current `cnt`, `cnt` wraps through 2^DIV_W. This is accepted behaviour, not an error.
- **Step:**
  - `q <= rot(q, dir_eff, amt)`; `step_pulse` = 1.
  - `dir` and `amt` are sampled in the step cycle only.
  - `amt`=0 still fires the step with `q` unchanged.
- **Load:**
  - `q <= pattern` and `cnt <= 0`, accepted in either state.
  - The state is unchanged.
  - `load` beats a step in the same cycle: no `step_pulse`.
- **Start/stop side effects:**
  - `start` clears `cnt`.
  - `stop` freezes `q` and `cnt`; `stop` in IDLE has no effect.
- **Reset:** asynchronous assertion at any time, including mid-run. It forces:
  - `q`=8'h00, `cnt`=0, state=IDLE.
  - `step_pulse`=0, `running`=0.
  - The bounce counter and internal direction (see Configuration) are also cleared.

## Timing
- Outputs are registered, with no combinational input-to-output paths.
- `running` rises 1 cycle after `start`.
- The first step's `step_pulse` and new `q` appear `div`+1 cycles after `running` rises.
- Subsequent steps occur every `div`+1 cycles.
- `load` is visible on `q` the next cycle.
- `stop` takes effect the next cycle. A step scheduled in the same cycle as `stop` is suppressed.

## Configuration
- Macro: `MARQUEE_BOUNCE_EN`.
- **Defined (ping-pong direction):**
  - An internal direction register `dir_r` is loaded from `dir` on `start` and on `load`.
  - A 3-bit step counter increments each step. When it reaches 7 it clears and `dir_r` toggles, so the toggle applies from the 8th step onward.
  - `dir_eff` = `dir_r`; `dir` is ignored while running.
- **Not defined:**
  - `dir_eff` = `dir` on every step.
  - No bounce logic is synthesized.

## Structure
- Package `marquee_pkg` holds:
  - `typedef enum logic {IDLE, RUN} marquee_state_t`.
  - localparams `PAT_W`=8 and `AMT_W`=3.
- The module instantiates one `barrelshifter` (`lr`=`dir_eff`, `a`=`q`, `amt`=`amt`) and registers its `y`. No other sub-modules.
- Prescaler, FSM and bounce logic are each a separate `always_ff` block.

## Test plan
- **Reset mid-run:**
  - Stimulus: load 8'hA5, start with `div`=3, assert `rst_n`=0 asynchronously between clock edges.
  - Required: `q`=8'h00, `running`=0, `step_pulse`=0 immediately; no step after release.
- **Basic chase:**
  - Stimulus: load 8'h01, `dir`=1, `amt`=1, `div`=2, start.
  - Required: `q` = 02, 04, 08… with `step_pulse` every 3 cycles; the first step 3 cycles after `running` rises.
- **Right rotate wrap:**
  - Stimulus: load 8'h01, `dir`=0, `amt`=3, `div`=0.
  - Required: `q` = 20, 04, 80, 10 on consecutive cycles.
- **Simultaneous events:**
  - `load` in a step cycle → `q`=`pattern`, no `step_pulse`.
  - `start`+`stop` together in IDLE → stays IDLE.
  - `stop` in a step cycle → `q` unchanged.
- **`amt`=0:**
  - Stimulus: load 8'h3C, run with `div`=1.
  - Required: `step_pulse` every 2 cycles, `q` stays 8'h3C.
- **Bounce (only with `MARQUEE_BOUNCE_EN`):**
  - Stimulus: load 8'h01, `dir`=1, `amt`=1, `div`=0.
  - Required: `q` = 02…80 over 7 steps, then 40, 20…; `dir` input changes mid-run have no effect.
